// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types and constants for the PS/2 key event receiver:
//            frame FSM state encoding, prefix scan codes, the packed key
//            event record and an odd-parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // 'release' is a language keyword, so the break flag is called 'released'
    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } ps2_event_t;

    localparam int PS2_EVT_W = $bits(ps2_event_t);

    // PS/2 uses odd parity: data ones plus the parity bit must be odd
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_event_fifo
// Purpose  : First-word-fall-through FIFO holding completed key events.
//            A push while full is accepted only when a pop happens in the
//            same cycle; otherwise it is ignored (caller reports overflow).
// Ports    : clk/rst_n      - clock, asynchronous active-low reset
//            push/wdata     - write request and data
//            pop            - read request (ignored when empty)
//            rdata          - head entry, valid while !empty
//            empty/full     - status flags
//            count          - current number of entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        // when full, the slot being written is the head that is leaving now
        do_push = push && (!full || do_pop);

        // DEPTH is a power of two, so pointers wrap naturally
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage is not reset; it is only observed through a non-empty count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_rx
// Purpose  : PS/2 keyboard receiver. Synchronises and glitch-filters the
//            PS/2 pins, decodes 11-bit frames, folds E0/F0 prefixes into the
//            following scan code and queues key events in a FWFT FIFO.
// Ports    : clock, reset (async, active-low)
//            ps2Clk, ps2Data           - raw PS/2 pins
//            keyCode/keyRelease/keyExtended/keyValid, keyReady - event stream
//            frameError, overflow      - one-cycle error pulses
//            fifoLevel                 - queued event count
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ps2Clk,
    input  logic                        ps2Data,
    output logic [7:0]                  keyCode,
    output logic                        keyRelease,
    output logic                        keyExtended,
    output logic                        keyValid,
    input  logic                        keyReady,
    output logic                        frameError,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifoLevel
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    // ------------------------------------------------------------------
    // Synchroniser and clock filter
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q,  clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   sync_clk, sync_data;
    logic                   filt_q, filt_d;
    logic [FCW-1:0]         fcnt_q, fcnt_d;
    logic                   filt_fall;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0],  ps2Clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2Data};
        sync_clk    = clk_sync_q[SYNC_STAGES-1];
        sync_data   = data_sync_q[SYNC_STAGES-1];
    end

    // fcnt counts consecutive samples that disagree with the filtered level;
    // any agreeing sample restarts the count, so short glitches are dropped.
    always_comb begin
        filt_d    = filt_q;
        fcnt_d    = '0;
        filt_fall = 1'b0;
        if (sync_clk != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d    = sync_clk;
                filt_fall = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    ps2_state_e     state_q, state_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           par_err_q, par_err_d;
    logic           timeout_hit;
    logic           frame_err_det;
    logic           byte_ok;

    always_comb begin
        timeout_hit = (state_q != IDLE) && !filt_fall &&
                      (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));
        to_cnt_d    = (filt_fall || (state_q == IDLE) || timeout_hit) ?
                      '0 : to_cnt_q + 1'b1;
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (filt_fall) begin
            case (state_q)
                IDLE:    state_d = sync_data ? IDLE : DATA;
                DATA:    state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // frame outcome
    always_comb begin
        frame_err_det = timeout_hit;
        byte_ok       = 1'b0;
        if (filt_fall) begin
            case (state_q)
                IDLE: frame_err_det = sync_data;
                STOP: begin
                    if (sync_data && !par_err_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err_det = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // frame datapath
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_err_d = par_err_q;
        if (filt_fall) begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                end
                DATA: begin
                    shift_d   = {sync_data, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                PARITY:  par_err_d = !odd_parity_ok(shift_q, sync_data);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prefix assembler and event queue
    // ------------------------------------------------------------------
    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic       push, pop;
    logic       overflow_det;
    logic       fifo_empty, fifo_full;
    ps2_event_t push_evt, head;
    logic       frame_error_q, overflow_q;

    always_comb begin
        push_evt.extended = ext_q;
        push_evt.released = rel_q;
        push_evt.code     = shift_q;

        pop          = !fifo_empty && keyReady;
        push         = 1'b0;
        ext_d        = ext_q;
        rel_d        = rel_q;
        if (byte_ok) begin
            if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                rel_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
        overflow_det = push && fifo_full && !pop;
        if (frame_err_det || overflow_det) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q    <= '1;
            data_sync_q   <= '1;
            filt_q        <= 1'b1;
            fcnt_q        <= '0;
            to_cnt_q      <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            par_err_q     <= 1'b0;
            ext_q         <= 1'b0;
            rel_q         <= 1'b0;
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            clk_sync_q    <= clk_sync_d;
            data_sync_q   <= data_sync_d;
            filt_q        <= filt_d;
            fcnt_q        <= fcnt_d;
            to_cnt_q      <= to_cnt_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            par_err_q     <= par_err_d;
            ext_q         <= ext_d;
            rel_q         <= rel_d;
            frame_error_q <= frame_err_det;
            overflow_q    <= overflow_det;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVT_W)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (push),
        .wdata (push_evt),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifoLevel)
    );

    // head fields are forced to zero while nothing is queued
    always_comb begin
        keyValid    = !fifo_empty;
        keyCode     = keyValid ? head.code     : 8'h00;
        keyRelease  = keyValid ? head.released : 1'b0;
        keyExtended = keyValid ? head.extended : 1'b0;
        frameError  = frame_error_q;
        overflow    = overflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_event_rx
// Purpose  : Self-checking bench for ps2_key_event_rx. A queue-based model of
//            the expected key events is updated from the frames the bench
//            sends; a compare process checks every handshake and counts
//            error/overflow pulses. Literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_rx;

    localparam int HP     = 25;    // half PS/2 clock period in system cycles
    localparam int TO     = 2000;
    localparam int DEPTH  = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ps2Clk = 1'b1;
    logic          ps2Data = 1'b1;
    logic          keyReady = 1'b0;
    logic [7:0]    keyCode;
    logic          keyRelease, keyExtended, keyValid;
    logic          frameError, overflow;
    logic [LW-1:0] fifoLevel;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    logic err_prev = 1'b0;
    logic ovf_prev = 1'b0;
    int rdy_mode = 0;               // 0: bench-driven, 1: random

    logic [9:0] exp_q[$];           // {ext, rel, code} expected in the DUT queue
    logic [9:0] popped[$];          // everything consumed, in order
    bit m_ext = 1'b0;
    bit m_rel = 1'b0;

    ps2_key_event_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock       (clk),
        .reset       (rst_n),
        .ps2Clk      (ps2Clk),
        .ps2Data     (ps2Data),
        .keyCode     (keyCode),
        .keyRelease  (keyRelease),
        .keyExtended (keyExtended),
        .keyValid    (keyValid),
        .keyReady    (keyReady),
        .frameError  (frameError),
        .overflow    (overflow),
        .fifoLevel   (fifoLevel)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        if (rst_n) begin
            if (frameError) begin
                check("frame_err_single_cycle", {31'd0, err_prev}, 0);
                err_seen++;
            end
            if (overflow) begin
                check("overflow_single_cycle", {31'd0, ovf_prev}, 0);
                ovf_seen++;
            end
            if (keyValid && keyReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=%0h required=none",
                             {keyExtended, keyRelease, keyCode});
                end else begin
                    check("pop_event", {22'd0, keyExtended, keyRelease, keyCode},
                          {22'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                popped.push_back({keyExtended, keyRelease, keyCode});
            end
        end
        err_prev = frameError;
        ovf_prev = overflow;
    end

    // random consumer
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) keyReady = 1'($urandom_range(0, 1));
        end
    end

    // reference rules for one received byte
    task automatic model_byte(input logic [7:0] b, input bit ok, input bit allow_full,
                              output int e_err, output int e_ovf);
        e_err = 0;
        e_ovf = 0;
        if (!ok) begin
            e_err = 1;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH && !allow_full) e_ovf = 1;
            else exp_q.push_back({m_ext, m_rel, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    // one PS/2 bit; optional one-cycle keyReady pulse aligned with the push
    task automatic send_bit(input logic b, input bit pulse);
        ps2Data = b;
        repeat (HP) begin @(posedge clk); #1; end
        ps2Clk = 1'b0;
        for (int i = 1; i <= HP; i++) begin
            @(posedge clk);
            #1;
            if (pulse && i == 5) keyReady = 1'b1;
            if (pulse && i == 6) keyReady = 1'b0;
        end
        ps2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pulse);
        int e0, o0, e_err, e_ovf;
        logic par;
        e0  = err_seen;
        o0  = ovf_seen;
        par = (~^b) ^ bad_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(par, 1'b0);
        model_byte(b, !bad_par && !bad_stop, pulse, e_err, e_ovf);
        send_bit(!bad_stop, pulse);
        ps2Data = 1'b1;
        repeat (HP) begin @(posedge clk); #1; end
        check("frame_err_count", err_seen - e0, e_err);
        check("overflow_count", ovf_seen - o0, e_ovf);
    endtask

    task automatic send_partial(input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        ps2Data = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        keyReady = 1'b1;
        while (keyValid && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        keyReady = 1'b0;
        @(posedge clk);
        #1;
        check("drain_level", fifoLevel, 0);
        check("drain_model_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_keyCode", keyCode, 0);
        check("rst_keyRelease", keyRelease, 0);
        check("rst_keyExtended", keyExtended, 0);
        check("rst_keyValid", keyValid, 0);
        check("rst_frameError", frameError, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fifoLevel", fifoLevel, 0);
    endtask

    initial begin
        int e0, base;
        logic [7:0] b;
        bit bp, bs;

        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end

        // make code
        send_frame(8'h1C, 0, 0, 0);
        check("make_level", fifoLevel, 1);
        check("make_valid", keyValid, 1);
        drain();
        check("make_literal", popped[popped.size()-1], 10'h01C);

        // break and extended prefixes
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        check("prefix_level", fifoLevel, 2);
        drain();
        check("brk_literal", popped[popped.size()-2], 10'h11C);
        check("ext_brk_literal", popped[popped.size()-1], 10'h375);

        // parity and stop errors drop the frame and stale prefixes
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 1, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h1C, 0, 1, 0);
        check("err_level", fifoLevel, 0);
        send_frame(8'h1C, 0, 0, 0);
        drain();
        check("after_err_literal", popped[popped.size()-1], 10'h01C);

        // inter-bit timeout
        send_frame(8'hE0, 0, 0, 0);
        e0 = err_seen;
        send_partial(4);
        repeat (TO + 200) begin @(posedge clk); #1; end
        check("timeout_err", err_seen - e0, 1);
        m_ext = 1'b0;
        m_rel = 1'b0;
        send_frame(8'h29, 0, 0, 0);
        drain();
        check("after_timeout_literal", popped[popped.size()-1], 10'h029);

        // overflow, then full with simultaneous pop and push
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'h10 + i), 0, 0, 0);
        check("ovf_level", fifoLevel, DEPTH);
        send_frame(8'h20, 0, 0, 1);
        check("full_pop_push_level", fifoLevel, DEPTH);
        base = popped.size();
        drain();
        for (int i = 0; i < DEPTH; i++) begin
            check("ovf_order_literal", popped[base+i],
                  (i == DEPTH - 1) ? 10'h020 : 10'(8'h11 + i));
        end
        check("ovf_first_literal", popped[base-1], 10'h010);

        // glitches on ps2Clk with data high would error if sampled in IDLE
        e0 = err_seen;
        ps2Clk = 1'b0;
        @(posedge clk); #1;
        ps2Clk = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        ps2Clk = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ps2Clk = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check("glitch_no_sample", err_seen - e0, 0);
        send_frame(8'h5A, 0, 0, 0);
        drain();
        check("after_glitch_literal", popped[popped.size()-1], 10'h05A);

        // reset mid-frame after a pending E0 prefix
        send_frame(8'hE0, 0, 0, 0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs();
        ps2Data = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        send_frame(8'h1C, 0, 0, 0);
        drain();
        check("after_reset_literal", popped[popped.size()-1], 10'h01C);

        // randomized traffic with a random consumer
        rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hE0 || b == 8'hF0) b = 8'h34;
                end
            endcase
            bp = ($urandom_range(0, 11) == 0);
            bs = !bp && ($urandom_range(0, 11) == 0);
            send_frame(b, bp, bs, 0);
        end
        rdy_mode = 0;
        @(posedge clk); #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver: the next generation of the keyboard front end, sitting between the PS/2 pins and the VGA/game logic. It synchronises and filters ps2Clk/ps2Data and validates each 11-bit frame (start, parity, stop, inter-bit timeout). It folds E0 (extended) and F0 (break) prefixes into the following code and queues complete key events in a FIFO with a valid/ready handshake, reporting errors and overflow instead of silently corrupting codes.

## Interface
- SYNC_STAGES, default 2: synchroniser flops on ps2Clk and ps2Data (≥2).
- FILTER_LEN, default 4: consecutive identical synced ps2Clk samples needed to accept a level change (≥1).
- TIMEOUT_CYCLES, default 50000: clock cycles without an accepted falling edge that abort a partial frame.
- FIFO_DEPTH, default 8: event queue entries, power of two, ≥2.
- clock  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- ps2Clk  input  1  raw PS/2 clock pin.
- ps2Data  input  1  raw PS/2 data pin.
- keyCode  output  8  scan code of the head event.
- keyRelease  output  1  head event was preceded by F0.
- keyExtended  output  1  head event was preceded by E0.
- keyValid  output  1  FIFO not empty; head fields stable while high.
- keyReady  input  1  consumer accepts the head event when keyValid && keyReady.
- frameError  output  1  one-cycle pulse: bad start, parity, stop or timeout.
- overflow  output  1  one-cycle pulse: completed event dropped because FIFO full.
- fifoLevel  output  $clog2(FIFO_DEPTH)+1  current entry count.

## Operation
- Reset: all outputs 0, FSM IDLE, prefix flags clear, FIFO empty, filtered ps2Clk state = 1. Reset mid-frame discards the partial frame.
- Filter: filtered clock changes only after FILTER_LEN equal synced samples; a 1→0 change is a falling edge; ps2Data (synced) is sampled on that cycle.
- Frame FSM (one step per falling edge): IDLE: sample must be 0 → DATA, else frameError, stay IDLE. DATA: 8 bits LSB first, bit counter 0..7 → PARITY. PARITY: data ones + parity bit must be odd, else flag error. STOP: sample must be 1; on success and no parity error emit byte, else frameError. Always return to IDLE.
- Timeout counter resets on every falling edge and in IDLE; reaching TIMEOUT_CYCLES outside IDLE → frameError, IDLE.
- Byte assembler: E0 sets ext flag; F0 sets rel flag; any other byte pushes {ext, rel, byte} and clears both flags. Any frameError or overflow also clears both flags.
- FIFO: first-word-fall-through. Pop on keyValid && keyReady. Push when full with simultaneous pop is accepted; push when full without pop → overflow, event dropped, contents unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Pin edge to sampled bit: SYNC_STAGES + FILTER_LEN cycles.
- Stop-bit sample cycle N: push registered at N+1; keyValid high at N+1 when FIFO was empty.
- frameError/overflow: single cycle, registered, one cycle after the detecting sample/timeout.
- Pop: head advances the cycle after the handshake; fifoLevel updates the same edge.
- Maximum event rate is one per frame (~11 PS/2 clocks), far below one per cycle; no back-pressure to the keyboard.

## Structure
- Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, packed event struct {extended, release, code[7:0]} (10 bits).
- Sub-module ps2_event_fifo (parametrised depth/width, FWFT, count output); synchroniser, filter, frame FSM and assembler stay in the top.

## Test plan
- Make code: frame 0x1C, parity 0, stop 1 → one event keyCode=0x1C, keyRelease=0, keyExtended=0; fifoLevel 1 → 0 after pop.
- Break and extended: frames F0,1C then E0,F0,75 → events {0x1C, rel=1, ext=0}, {0x75, rel=1, ext=1} in order; prefixes produce no events.
- Parity error: 0x1C with parity 1 → frameError pulse, no event; next valid 0x1C decoded normally with no stale flags.
- Timeout: start + 4 data bits, ps2Clk held high for TIMEOUT_CYCLES → frameError once, FSM IDLE; following frame 0x29 decoded correctly.
- Overflow: keyReady=0, send FIFO_DEPTH+1 codes 0x10.. → fifoLevel=FIFO_DEPTH, one overflow pulse, drained codes are the first FIFO_DEPTH in order; full+simultaneous pop+push keeps level at FIFO_DEPTH.
- Glitch/reset: 1-cycle ps2Clk low glitch → no bit sampled; reset asserted mid-frame → all outputs 0, next frame decodes correctly.
